// File: rtl/stage_1_2_pipeline.sv
// stage_1_2_pipeline: two-stage range-coder update; stage 1 registers symbol bounds, stage 2 applies them to range/low.
module stage_1_2_pipeline #(
  parameter int RANGE_WIDTH    = 16,
  parameter int LOW_WIDTH      = 24,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_DATA_WIDTH = 16
) (
  input  logic                      general_clk,
  input  logic                      reset,
  input  logic                      reg_en,
  input  logic [RANGE_WIDTH-1:0]    FL,
  input  logic [RANGE_WIDTH-1:0]    FH,
  input  logic [SYMBOL_WIDTH-1:0]   SYMBOL,
  input  logic [SYMBOL_WIDTH:0]     NSYMS,
  input  logic [RANGE_WIDTH-1:0]    in_range,
  input  logic [LOW_WIDTH-1:0]      in_low,
  output logic [RANGE_WIDTH-1:0]    range,
  output logic [LOW_WIDTH-1:0]      low
);
  localparam int UW = 2 * RANGE_WIDTH + LUT_DATA_WIDTH + 2;
  logic                      comp_d, comp_q;
  logic [RANGE_WIDTH-1:0]    uu_d, uu_q, vv_d, vv_q;
  logic [LUT_DATA_WIDTH-1:0] lut_u_d, lut_u_q, lut_v_d, lut_v_q, span;
  logic [UW-1:0]             r8, u, v;
  always_comb begin
    span    = LUT_DATA_WIDTH'(NSYMS) - LUT_DATA_WIDTH'(SYMBOL);
    comp_d  = reg_en ? (FL < RANGE_WIDTH'(32768)) : comp_q;
    uu_d    = reg_en ? FL >> 6 : uu_q;
    vv_d    = reg_en ? FH >> 6 : vv_q;
    lut_u_d = reg_en ? span << 2 : lut_u_q;
    lut_v_d = reg_en ? (span << 2) - LUT_DATA_WIDTH'(4) : lut_v_q;
    // wide datapath keeps the full product before the halving shift
    r8      = UW'(in_range >> 8);
    u       = ((r8 * UW'(uu_q)) >> 1) + UW'(lut_u_q);
    v       = ((r8 * UW'(vv_q)) >> 1) + UW'(lut_v_q);
    range   = comp_q ? RANGE_WIDTH'(u - v) : in_range - RANGE_WIDTH'(v);
    low     = comp_q ? in_low + LOW_WIDTH'(in_range) - LOW_WIDTH'(u) : in_low;
  end
  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      comp_q  <= 1'b0;
      uu_q    <= '0;
      vv_q    <= '0;
      lut_u_q <= '0;
      lut_v_q <= '0;
    end else begin
      comp_q  <= comp_d;
      uu_q    <= uu_d;
      vv_q    <= vv_d;
      lut_u_q <= lut_u_d;
      lut_v_q <= lut_v_d;
    end
  end
endmodule

// File: tb/tb_stage_1_2_pipeline.sv
// tb_stage_1_2_pipeline: scoreboard bench; a reference model of the captured symbol predicts range/low.
module tb_stage_1_2_pipeline;
  logic        general_clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_en = 1'b0;
  logic [15:0] FL = '0, FH = '0;
  logic [3:0]  SYMBOL = '0;
  logic [4:0]  NSYMS = '0;
  logic [15:0] in_range = '0;
  logic [23:0] in_low = '0;
  logic [15:0] range;
  logic [23:0] low;
  int total = 0, bad = 0;
  longint m_comp = 0, m_uu = 0, m_vv = 0, m_lu = 0, m_lv = 0;
  logic [39:0] sb [$];

  stage_1_2_pipeline dut (
    .general_clk(general_clk), .reset(reset), .reg_en(reg_en),
    .FL(FL), .FH(FH), .SYMBOL(SYMBOL), .NSYMS(NSYMS),
    .in_range(in_range), .in_low(in_low), .range(range), .low(low)
  );

  always #5 general_clk = ~general_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] model(input longint ri, input longint li);
    longint r8, u, v, rr, ll;
    r8 = ri / 256;
    u = (r8 * m_uu) / 2 + m_lu;
    v = (r8 * m_vv) / 2 + m_lv;
    if (m_comp != 0) begin
      ll = (li + ri - u) & 64'hFFFFFF;
      rr = (u - v) & 64'hFFFF;
    end else begin
      ll = li;
      rr = (ri - v) & 64'hFFFF;
    end
    return {rr[15:0], ll[23:0]};
  endfunction

  task automatic model_clear();
    m_comp = 0; m_uu = 0; m_vv = 0; m_lu = 0; m_lv = 0;
  endtask

  task automatic model_load();
    m_comp = (FL < 16'd32768) ? 1 : 0;
    m_uu = longint'(FL) / 64;
    m_vv = longint'(FH) / 64;
    m_lu = (4 * (longint'(NSYMS) - longint'(SYMBOL))) & 64'hFFFF;
    m_lv = (4 * (longint'(NSYMS) - 1 - longint'(SYMBOL))) & 64'hFFFF;
  endtask

  task automatic apply(input string tag, input logic [15:0] ri, input logic [23:0] li);
    logic [39:0] e;
    in_range = ri;
    in_low = li;
    sb.push_back(model(longint'(ri), longint'(li)));
    #1;
    e = sb.pop_front();
    chk({tag, "_range"}, 64'(range), 64'(e[39:24]));
    chk({tag, "_low"}, 64'(low), 64'(e[23:0]));
  endtask

  task automatic load(input logic [15:0] fl, input logic [15:0] fh, input logic [3:0] s,
                      input logic [4:0] n, input logic en);
    @(negedge general_clk);
    FL = fl; FH = fh; SYMBOL = s; NSYMS = n; reg_en = en;
    @(posedge general_clk);
    if (en) model_load();
    #1;
  endtask

  initial begin
    in_range = 16'd50000;
    in_low = 24'd1234;
    #1;
    chk("rst_pass_range", 64'(range), 64'd50000);
    chk("rst_pass_low", 64'(low), 64'd1234);
    FL = 16'd16384; FH = 16'd8192; SYMBOL = 4'd1; NSYMS = 5'd3; reg_en = 1'b1;
    repeat (2) @(posedge general_clk);
    #1;
    apply("rst_override", 16'd50000, 24'd1234);
    @(negedge general_clk);
    reset = 1'b0;
    reg_en = 1'b0;
    #1;
    apply("post_rst", 16'd40000, 24'd77);
    load(16'd16384, 16'd8192, 4'd1, 5'd3, 1'b1);
    apply("comp1", 16'd32768, 24'd0);
    chk("comp1_range_lit", 64'(range), 64'd8196);
    chk("comp1_low_lit", 64'(low), 64'd16376);
    apply("lowwrap", 16'd32768, 24'd16777200);
    chk("lowwrap_low_lit", 64'(low), 64'd16360);
    chk("lowwrap_range_lit", 64'(range), 64'd8196);
    load(16'd32768, 16'd24576, 4'd0, 5'd2, 1'b0);
    apply("hold", 16'd32768, 24'd0);
    chk("hold_range_lit", 64'(range), 64'd8196);
    chk("hold_low_lit", 64'(low), 64'd16376);
    reg_en = 1'b1;
    #1;
    apply("latency_mid", 16'd32768, 24'd0);
    @(posedge general_clk);
    model_load();
    #1;
    apply("comp0", 16'd40000, 24'd100);
    chk("comp0_range_lit", 64'(range), 64'd10044);
    chk("comp0_low_lit", 64'(low), 64'd100);
    load(16'd1000, 16'd200, 4'd5, 5'd2, 1'b1);
    apply("oob_wrap", 16'd65535, 24'd5);
    @(negedge general_clk);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    apply("midrst", 16'd12345, 24'd999);
    @(negedge general_clk);
    reset = 1'b0;
    reg_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      load(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      apply("rand_a", 16'($urandom_range(0, 65535)), 24'($urandom_range(0, 16777215)));
      apply("rand_b", 16'($urandom_range(0, 65535)), 24'($urandom_range(0, 16777215)));
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
